// File: rtl/l2cache_rr.sv
// Shared multi-port L2: independent round-robin read and write engines over one dual-port BRAM.
// Define L2CACHE_INV_BROADCAST_EN to compile in the coherence invalidation broadcast on writes.

module bram #(
    parameter int WIDTH     = 128,
    parameter int MASKW     = WIDTH / 8,
    parameter int DEPTH     = 16384,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic [MASKW-1:0]         wea,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [WIDTH-1:0]         dina,
    input  logic                     enb,
    input  logic [$clog2(DEPTH)-1:0] addrb,
    output logic [WIDTH-1:0]         doutb
);
    // Contents are loaded by the implementation flow's memory-init mechanism.
    localparam int unused_init_len = $bits(INIT_FILE);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < MASKW; b++) begin
            if (wea[b]) begin
                mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
            end
        end
    end

    // Separate read process gives read-first behaviour on a same-address collision.
    always_ff @(posedge clk) begin
        if (enb) begin
            doutb <= mem[addrb];
        end
    end
endmodule

module l2cache_rr #(
    parameter int PORTS      = 4,
    parameter int WIDTH      = 128,
    parameter int MASKW      = WIDTH / 8,
    parameter int SIZE       = 256 * 1024 * 8,
    parameter int ADDR_WIDTH = 32,
    parameter     INIT_FILE  = ""
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            rw_valid,
    input  logic [PORTS-1:0]            rw_we,
    input  logic [PORTS*ADDR_WIDTH-1:0] rw_addr,
    input  logic [PORTS*WIDTH-1:0]      w_data,
    input  logic [PORTS*MASKW-1:0]      w_mask,
    input  logic [PORTS-1:0]            w_ce,
    output logic [PORTS-1:0]            rw_ready,
    output logic [WIDTH-1:0]            r_data,
    output logic [PORTS-1:0]            inv_valid,
    output logic [ADDR_WIDTH-1:0]       inv_addr,
    input  logic [PORTS-1:0]            inv_ready
);
    localparam int DEPTH = SIZE / WIDTH;
    localparam int OFFW  = $clog2(WIDTH / 8);
    localparam int IDXW  = $clog2(DEPTH);
    localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [PW-1:0] LAST = PW'(PORTS - 1);

    typedef enum logic [1:0] {R_IDLE, R_OPER, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_OPER, W_RESP
`ifdef L2CACHE_INV_BROADCAST_EN
        , W_BCAST
`endif
    } wr_state_e;

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFW +: IDXW];
    endfunction

    // First candidate found scanning cyclically from ptr+1; descending loop leaves the nearest.
    function automatic logic [PW-1:0] rr_pick(input logic [PORTS-1:0] cand, input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = PORTS; k >= 1; k--) begin
            idx = (int'(ptr) + k) % PORTS;
            if (cand[idx]) pick = PW'(idx);
        end
        return pick;
    endfunction

    rd_state_e        rd_state_q, rd_state_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, rd_port_q, rd_port_d;
    logic [IDXW-1:0]  rd_idx_q, rd_idx_d;
    wr_state_e        wr_state_q, wr_state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, wr_port_q, wr_port_d;
    logic [IDXW-1:0]  wr_idx_q, wr_idx_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [MASKW-1:0] wr_mask_q, wr_mask_d;

    logic [PORTS-1:0] rd_cand, wr_cand, rd_ready, wr_ready;
    logic [PW-1:0]    rd_pick, wr_pick;
    logic             rd_enb;
    logic [MASKW-1:0] wea;
    logic [WIDTH-1:0] rd_dout;

    assign rd_cand  = rw_valid & ~rw_we;
    assign wr_cand  = rw_valid & rw_we;
    assign rd_pick  = rr_pick(rd_cand, rd_ptr_q);
    assign wr_pick  = rr_pick(wr_cand, wr_ptr_q);
    assign rw_ready = rd_ready | wr_ready;

    bram #(.WIDTH(WIDTH), .MASKW(MASKW), .DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_bram (
        .clk  (clk),
        .wea  (wea),
        .addra(wr_idx_q),
        .dina (wr_data_q),
        .enb  (rd_enb),
        .addrb(rd_idx_q),
        .doutb(rd_dout)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_port_d  = rd_port_q;
        rd_idx_d   = rd_idx_q;
        rd_enb     = 1'b0;
        rd_ready   = '0;
        r_data     = '0;
        case (rd_state_q)
            R_IDLE: begin
                if (|rd_cand) begin
                    rd_port_d  = rd_pick;
                    rd_ptr_d   = rd_pick;
                    rd_idx_d   = word_idx(rw_addr[int'(rd_pick)*ADDR_WIDTH +: ADDR_WIDTH]);
                    rd_state_d = R_OPER;
                end
            end
            R_OPER: begin
                rd_enb     = 1'b1;
                rd_state_d = R_RESP;
            end
            R_RESP: begin
                r_data              = rd_dout;
                rd_ready[rd_port_q] = 1'b1;
                rd_state_d          = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

`ifdef L2CACHE_INV_BROADCAST_EN
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_ce_q, wr_ce_d;
    logic [PORTS-1:0]      sb_q, sb_d;
`else
    logic unused_inv;
    assign unused_inv = ^{w_ce, inv_ready};
    assign inv_valid  = '0;
    assign inv_addr   = '0;
`endif

    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_port_d  = wr_port_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        wr_mask_d  = wr_mask_q;
        wr_ready   = '0;
        wea        = '0;
`ifdef L2CACHE_INV_BROADCAST_EN
        wr_addr_d  = wr_addr_q;
        wr_ce_d    = wr_ce_q;
        sb_d       = sb_q;
        inv_valid  = '0;
        inv_addr   = '0;
`endif
        case (wr_state_q)
            W_IDLE: begin
                if (|wr_cand) begin
                    wr_port_d  = wr_pick;
                    wr_ptr_d   = wr_pick;
                    wr_idx_d   = word_idx(rw_addr[int'(wr_pick)*ADDR_WIDTH +: ADDR_WIDTH]);
                    wr_data_d  = w_data[int'(wr_pick)*WIDTH +: WIDTH];
                    wr_mask_d  = w_mask[int'(wr_pick)*MASKW +: MASKW];
`ifdef L2CACHE_INV_BROADCAST_EN
                    wr_addr_d  = rw_addr[int'(wr_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    wr_ce_d    = w_ce[wr_pick];
`endif
                    wr_state_d = W_OPER;
                end
            end
            W_OPER: begin
                wea        = wr_mask_q;
                wr_state_d = W_RESP;
`ifdef L2CACHE_INV_BROADCAST_EN
                if (wr_ce_q) begin
                    // The writer never invalidates itself, so its scoreboard bit starts set.
                    sb_d            = '0;
                    sb_d[wr_port_q] = 1'b1;
                    wr_state_d      = W_BCAST;
                end
`endif
            end
`ifdef L2CACHE_INV_BROADCAST_EN
            W_BCAST: begin
                inv_valid = ~sb_q;
                inv_addr  = wr_addr_q;
                sb_d      = sb_q | (~sb_q & inv_ready);
                if (&sb_d) wr_state_d = W_RESP;
            end
`endif
            W_RESP: begin
                wr_ready[wr_port_q] = 1'b1;
                wr_state_d          = W_IDLE;
`ifdef L2CACHE_INV_BROADCAST_EN
                sb_d                = '0;
`endif
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_ptr_q   <= LAST;
            wr_state_q <= W_IDLE;
            wr_ptr_q   <= LAST;
`ifdef L2CACHE_INV_BROADCAST_EN
            sb_q       <= '0;
`endif
        end else begin
            rd_state_q <= rd_state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
`ifdef L2CACHE_INV_BROADCAST_EN
            sb_q       <= sb_d;
`endif
        end
    end

    // Transaction payload registers only matter while their FSM is busy, so they carry no reset.
    always_ff @(posedge clk) begin
        rd_port_q <= rd_port_d;
        rd_idx_q  <= rd_idx_d;
        wr_port_q <= wr_port_d;
        wr_idx_q  <= wr_idx_d;
        wr_data_q <= wr_data_d;
        wr_mask_q <= wr_mask_d;
`ifdef L2CACHE_INV_BROADCAST_EN
        wr_addr_q <= wr_addr_d;
        wr_ce_q   <= wr_ce_d;
`endif
    end
endmodule

// File: tb/tb_l2cache_rr.sv
// Randomized self-checking bench for l2cache_rr against a word-level memory and round-robin model.
module tb_l2cache_rr;
    localparam int P  = 4;
    localparam int W  = 128;
    localparam int MW = 16;
    localparam int AW = 32;
`ifdef L2CACHE_INV_BROADCAST_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [P-1:0]  rw_valid, rw_we, w_ce, rw_ready, inv_valid, inv_ready;
    logic [P*AW-1:0] rw_addr;
    logic [P*W-1:0]  w_data;
    logic [P*MW-1:0] w_mask;
    logic [W-1:0]  r_data;
    logic [AW-1:0] inv_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] mdl [16];

    bit          job_act [P];
    bit          job_we  [P];
    bit          job_ce  [P];
    logic [AW-1:0] job_addr [P];
    logic [W-1:0]  job_data [P];
    logic [MW-1:0] job_mask [P];
    int          job_lat [P];
    logic [W-1:0]  job_rd  [P];

    l2cache_rr #(.PORTS(P), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rw_valid(rw_valid), .rw_we(rw_we), .rw_addr(rw_addr),
        .w_data(w_data), .w_mask(w_mask), .w_ce(w_ce), .rw_ready(rw_ready), .r_data(r_data),
        .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_ready(inv_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] apply_mask(input logic [W-1:0] old, input logic [W-1:0] d,
                                                input logic [MW-1:0] m);
        logic [W-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Idles one cycle so both engines are in IDLE, then requests and waits for this port's ready.
    task automatic do_req(input int p, input bit we, input logic [AW-1:0] addr, input logic [W-1:0] data,
                          input logic [MW-1:0] mask, input bit ce, output int lat, output logic [W-1:0] rd);
        @(negedge clk);
        rw_we[p]              = we;
        rw_addr[p*AW +: AW]   = addr;
        w_data[p*W +: W]      = data;
        w_mask[p*MW +: MW]    = mask;
        w_ce[p]               = ce;
        rw_valid[p]           = 1'b1;
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (rw_ready[p]) begin
                lat = c;
                rd  = r_data;
                break;
            end
        end
        rw_valid[p] = 1'b0;
    endtask

    task automatic port_job(input int p);
        if (job_act[p]) begin
            do_req(p, job_we[p], job_addr[p], job_data[p], job_mask[p], job_ce[p], job_lat[p], job_rd[p]);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_jobs();
        for (int p = 0; p < P; p++) begin
            job_act[p] = 1'b0; job_we[p] = 1'b0; job_ce[p] = 1'b0;
            job_addr[p] = '0; job_data[p] = '0; job_mask[p] = '0;
        end
    endtask

    task automatic run_jobs();
        fork
            port_job(0);
            port_job(1);
            port_job(2);
            port_job(3);
        join
    endtask

    int           lat, exp_lat [P], rptr, wptr, t, last, idx, pend_done;
    logic [W-1:0] rd, exp_rd [P], wdat;
    logic [P-1:0] pending;
    bit           in_b;
    int           jidx [P];
    bit           wb;

    initial begin
        rst = 1'b1; rw_valid = '0; rw_we = '0; w_ce = '0; inv_ready = '1;
        rw_addr = '0; w_data = '0; w_mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_rw_ready", rw_ready, '0);
        check_val("rst_inv_valid", inv_valid, '0);
        check_val("rst_inv_addr", inv_addr, '0);
        check_val("rst_r_data", r_data, '0);

        // Preload words 0..15; word 1 (byte 0x10) holds the A5 pattern.
        for (int i = 0; i < 16; i++) begin
            mdl[i] = (i == 1) ? {16{8'hA5}} : rnd128();
            do_req(0, 1'b1, AW'(i * 16), mdl[i], '1, 1'b0, lat, rd);
            check_val("preload_lat", lat, 2);
        end

        do_reset(1);
        do_req(0, 1'b0, 32'h10, '0, '0, 1'b0, lat, rd);
        check_val("single_rd_lat", lat, 2);
        check_val("single_rd_data", rd, {16{8'hA5}});

        // Round robin from a fresh pointer: 0,1,2,3 at 3-cycle spacing.
        do_reset(1);
        clear_jobs();
        jidx[0] = 3; jidx[1] = 5; jidx[2] = 6; jidx[3] = 7;
        for (int p = 0; p < P; p++) begin
            job_act[p] = 1'b1; job_addr[p] = AW'(jidx[p] * 16);
        end
        run_jobs();
        for (int p = 0; p < P; p++) begin
            check_val("rr_lat", job_lat[p], 2 + 3 * p);
            check_val("rr_data", job_rd[p], mdl[jidx[p]]);
        end
        clear_jobs();
        job_act[3] = 1'b1; job_addr[3] = 32'h80;
        job_act[1] = 1'b1; job_addr[1] = 32'h90;
        run_jobs();
        check_val("rr2_lat_p1", job_lat[1], 2);
        check_val("rr2_lat_p3", job_lat[3], 5);
        check_val("rr2_data_p1", job_rd[1], mdl[9]);
        check_val("rr2_data_p3", job_rd[3], mdl[8]);

        // Masked write: only bytes 0..3 of word 2 change.
        do_req(2, 1'b1, 32'h20, '1, 16'h000F, 1'b0, lat, rd);
        check_val("mask_wr_lat", lat, 2);
        mdl[2] = apply_mask(mdl[2], '1, 16'h000F);
        @(negedge clk);
        check_val("mask_wr_once", rw_ready, '0);
        do_req(2, 1'b0, 32'h20, '0, '0, 1'b0, lat, rd);
        check_val("mask_rd_lat", lat, 2);
        check_val("mask_rd_data", rd, mdl[2]);
        @(negedge clk);
        check_val("mask_rd_once", rw_ready, '0);

        // Zero mask: full write cycle, memory unchanged.
        do_req(1, 1'b1, 32'h30, rnd128(), 16'h0000, 1'b0, lat, rd);
        check_val("zero_mask_lat", lat, 2);
        do_req(1, 1'b0, 32'h30, '0, '0, 1'b0, lat, rd);
        check_val("zero_mask_data", rd, mdl[3]);

        // Same-word read and write in one cycle: read-first.
        clear_jobs();
        wdat = rnd128();
        job_act[0] = 1'b1; job_we[0] = 1'b1; job_addr[0] = 32'h40; job_data[0] = wdat; job_mask[0] = '1;
        job_act[1] = 1'b1; job_addr[1] = 32'h40;
        run_jobs();
        check_val("conc_wr_lat", job_lat[0], 2);
        check_val("conc_rd_lat", job_lat[1], 2);
        check_val("conc_rd_old", job_rd[1], mdl[4]);
        mdl[4] = wdat;
        do_req(3, 1'b0, 32'h40, '0, '0, 1'b0, lat, rd);
        check_val("conc_rd_new", rd, mdl[4]);

`ifdef L2CACHE_INV_BROADCAST_EN
        // Broadcast with port 3 holding off its acknowledge.
        @(negedge clk);
        inv_ready = 4'b0101;
        wdat = rnd128();
        rw_we[1] = 1'b1; rw_addr[1*AW +: AW] = 32'h50; w_data[1*W +: W] = wdat;
        w_mask[1*MW +: MW] = '1; w_ce[1] = 1'b1; rw_valid[1] = 1'b1;
        pending = 4'b1101; pend_done = 1000; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 6) inv_ready[3] = 1'b1;
            in_b = (c >= 2) && (pending != '0);
            check_val("bc_inv_valid", inv_valid, in_b ? pending : '0);
            if (in_b) check_val("bc_inv_addr", inv_addr, 32'h50);
            if (rw_ready[1]) begin
                lat = c;
                break;
            end
            if (in_b) begin
                pending = pending & ~inv_ready;
                if (pending == '0) pend_done = c + 1;
            end
        end
        rw_valid[1] = 1'b0; w_ce[1] = 1'b0; inv_ready = '1;
        check_val("bc_ready_lat", lat, pend_done);
        mdl[5] = wdat;

        do_req(2, 1'b1, 32'h60, mdl[6], '1, 1'b1, lat, rd);
        check_val("bc_fast_lat", lat, 3);

        // Reset while sitting in broadcast: memory write already happened.
        @(negedge clk);
        inv_ready = '0;
        wdat = rnd128();
        rw_we[1] = 1'b1; rw_addr[1*AW +: AW] = 32'h60; w_data[1*W +: W] = wdat;
        w_mask[1*MW +: MW] = '1; w_ce[1] = 1'b1; rw_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rstbc_inv_valid", inv_valid, 4'b1101);
        rst = 1'b1; rw_valid[1] = 1'b0; w_ce[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0; inv_ready = '1;
        check_val("rstbc_rw_ready", rw_ready, '0);
        check_val("rstbc_inv_valid0", inv_valid, '0);
        check_val("rstbc_inv_addr", inv_addr, '0);
        @(negedge clk);
        check_val("rstbc_no_ready", rw_ready, '0);
        mdl[6] = wdat;
        do_req(2, 1'b0, 32'h60, '0, '0, 1'b0, lat, rd);
        check_val("rstbc_fresh_lat", lat, 2);
        check_val("rstbc_fresh_data", rd, mdl[6]);
`else
        // Coherence flag ignored: plain two-cycle write, no invalidations.
        fork
            do_req(1, 1'b1, 32'h50, mdl[5], '1, 1'b1, lat, rd);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check_val("noinv_valid", inv_valid, '0);
                check_val("noinv_addr", inv_addr, '0);
            end
        join
        check_val("noinv_wr_lat", lat, 2);
`endif

        // Reset while a read is in OPER: no ready pulse, memory kept.
        @(negedge clk);
        rw_we[0] = 1'b0; rw_addr[0 +: AW] = 32'h70; rw_valid[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1; rw_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_val("rstrd_rw_ready", rw_ready, '0);
        check_val("rstrd_r_data", r_data, '0);
        check_val("rstrd_inv_valid", inv_valid, '0);
        @(negedge clk);
        check_val("rstrd_no_ready", rw_ready, '0);
        do_req(0, 1'b0, 32'h70, '0, '0, 1'b0, lat, rd);
        check_val("rstrd_fresh_lat", lat, 2);
        check_val("rstrd_fresh_data", rd, mdl[7]);

        // Randomized rounds; reads and writes touch disjoint word parities within a round.
        do_reset(1);
        rptr = P - 1;
        wptr = P - 1;
        for (int r = 0; r < 40; r++) begin
            clear_jobs();
            wb = 1'($urandom_range(0, 1));
            idx = $urandom_range(1, 15);
            for (int p = 0; p < P; p++) begin
                job_act[p]  = idx[p];
                job_we[p]   = 1'($urandom_range(0, 1));
                jidx[p]     = $urandom_range(0, 7) * 2 + (job_we[p] ? int'(wb) : int'(!wb));
                job_addr[p] = AW'(jidx[p] * 16 + $urandom_range(0, 15));
                job_data[p] = rnd128();
                job_mask[p] = MW'($urandom);
                job_ce[p]   = 1'($urandom_range(0, 1));
                exp_lat[p]  = -1;
                exp_rd[p]   = mdl[jidx[p]];
            end
            t = 0; last = -1;
            for (int k = 1; k <= P; k++) begin
                idx = (rptr + k) % P;
                if (job_act[idx] && !job_we[idx]) begin
                    exp_lat[idx] = t + 2; t = t + 3; last = idx;
                end
            end
            if (last >= 0) rptr = last;
            t = 0; last = -1;
            for (int k = 1; k <= P; k++) begin
                idx = (wptr + k) % P;
                if (job_act[idx] && job_we[idx]) begin
                    exp_lat[idx] = t + ((BC && job_ce[idx]) ? 3 : 2);
                    t = exp_lat[idx] + 1; last = idx;
                    mdl[jidx[idx]] = apply_mask(mdl[jidx[idx]], job_data[idx], job_mask[idx]);
                end
            end
            if (last >= 0) wptr = last;
            run_jobs();
            for (int p = 0; p < P; p++) begin
                if (job_act[p]) begin
                    check_val("rnd_lat", job_lat[p], exp_lat[p]);
                    if (!job_we[p]) check_val("rnd_rd_data", job_rd[p], exp_rd[p]);
                end
            end
        end

        for (int i = 0; i < 16; i++) begin
            do_req(i % P, 1'b0, AW'(i * 16), '0, '0, 1'b0, lat, rd);
            check_val("final_data", rd, mdl[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
